branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter ADDR_W, default 32, address and operand width.
REQ-002 Parameter FLUSH_CYCLES, default 2, wrong-path squash duration after a mispredict, legal range 1-15.
REQ-003 Parameter CNT_W, default 32, width of the performance counters.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rdy  in  1  global ready; 0 freezes all state and outputs.
REQ-007 ex_valid  in  1  EX-stage instruction present.
REQ-008 ex_stall  in  1  EX stalled; instruction not consumed this cycle.
REQ-009 is_br / is_jal / is_jalr  in  1 each  instruction class.
REQ-010 funct3  in  3  conditional branch type.
REQ-011 rs1_val, rs2_val  in  ADDR_W  source operands.
REQ-012 inst_pc  in  ADDR_W  instruction address.
REQ-013 imm  in  ADDR_W  sign-extended offset.
REQ-014 pred_next_pc  in  ADDR_W  address fetch used after this instruction.
REQ-015 prediction_res  out  1  1 = prediction correct, 0 = redirect fetch.
REQ-016 jumpaddr  out  ADDR_W  correct next PC when prediction_res=0.
REQ-017 branch_flag  out  1  one-cycle predictor-update strobe.
REQ-018 branch_taken  out  1  resolved direction for the update.
REQ-019 branch_pc, branch_target  out  ADDR_W each  update index and target.
REQ-020 flush  out  1  squash younger pipeline stages.
REQ-021 br_cnt, miss_cnt  out  CNT_W each  resolved-control and mispredict counts.

Function
REQ-022 An instruction is accepted when rdy=1, ex_valid=1, ex_stall=0, FSM in IDLE, and at least one is_* is set.
REQ-023 Class priority is is_jalr > is_jal > is_br when several are set.
REQ-024 Conditional take: 000 BEQ eq, 001 BNE ne, 100 BLT signed lt, 101 BGE signed ge, 110 BLTU unsigned lt, 111 BGEU unsigned ge; 010/011 resolve not-taken.
REQ-025 JAL and JALR are always taken.
REQ-026 Target is inst_pc+imm for BR/JAL and (rs1_val+imm) with bit0 cleared for JALR, all arithmetic modulo 2^ADDR_W.
REQ-027 actual_next = taken ? target : inst_pc+4; mispredict = (actual_next != pred_next_pc).
REQ-028 All outputs are registered; results appear exactly one cycle after acceptance.
REQ-029 On acceptance of BR or JAL: branch_flag=1 for one cycle, with branch_pc=inst_pc, branch_target=target, branch_taken=taken; JALR never asserts branch_flag.
REQ-030 On mispredict: prediction_res=0 and jumpaddr=actual_next for exactly one cycle, then prediction_res returns to 1.
REQ-031 FSM states are IDLE and SQUASH; mispredict moves IDLE to SQUASH.
REQ-032 flush is 1 from the prediction_res=0 cycle through FLUSH_CYCLES cycles total; the FSM then returns to IDLE.
REQ-033 In SQUASH, inputs are ignored: no branch_flag, no counting, no new redirect.
REQ-034 Every accepted instruction increments br_cnt; every mispredict increments miss_cnt; both saturate at all-ones.
REQ-035 When rdy=0, FSM, counters and all outputs hold, including a pending one-cycle strobe, which is re-presented unchanged.
REQ-036 With ex_stall=1 or ex_valid=0 in IDLE, branch_flag=0, prediction_res=1, flush=0.

Reset
REQ-037 Reset values: prediction_res=1, branch_flag=0, flush=0, FSM=IDLE; all addresses 0; branch_taken=0; counters=0.
REQ-038 Reset asserted mid-SQUASH aborts the squash immediately; no strobe is emitted after release.

Verification
REQ-039 BEQ, inst_pc=0x100, imm=0x20, rs1=rs2=5, pred_next_pc=0x120 -> next cycle: branch_flag=1, branch_taken=1, branch_target=0x120, prediction_res=1, br_cnt=1.
REQ-040 BLT signed, rs1=0xFFFFFFFF, rs2=1, pred_next_pc=0x104 (inst_pc 0x100, imm 0x40) -> prediction_res=0, jumpaddr=0x140, flush high 2 cycles, miss_cnt=1.
REQ-041 JALR, rs1=0x2001, imm=0x4, pred 0x2004 -> jumpaddr=0x2004 not asserted (target 0x2004, correct), branch_flag=0, br_cnt increments.
REQ-042 Mispredict followed by valid BNE in both squash cycles -> no branch_flag, br_cnt unchanged for them.
REQ-043 rdy=0 in the cycle prediction_res=0 for 3 cycles -> prediction_res stays 0, jumpaddr constant, counters static; one cycle after rdy=1 it returns to 1.
REQ-044 Preload miss_cnt to all-ones via repeated mispredicts (CNT_W=4) -> 16th mispredict leaves miss_cnt=0xF.

Source files
------------

// File: rtl/branch_resolve_if.sv
// EX-stage branch resolution bus: instruction operands in, redirect/predictor-update results out.
interface branch_resolve_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              rdy;
    logic              ex_valid;
    logic              ex_stall;
    logic              is_br;
    logic              is_jal;
    logic              is_jalr;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] rs1_val;
    logic [ADDR_W-1:0] rs2_val;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] imm;
    logic [ADDR_W-1:0] pred_next_pc;

    logic              prediction_res;
    logic [ADDR_W-1:0] jumpaddr;
    logic              branch_flag;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] branch_target;
    logic              flush;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output rdy, ex_valid, ex_stall, is_br, is_jal, is_jalr, funct3,
               rs1_val, rs2_val, inst_pc, imm, pred_next_pc,
        input  prediction_res, jumpaddr, branch_flag, branch_taken,
               branch_pc, branch_target, flush, br_cnt, miss_cnt
    );

    modport slave (
        input  rdy, ex_valid, ex_stall, is_br, is_jal, is_jalr, funct3,
               rs1_val, rs2_val, inst_pc, imm, pred_next_pc,
        output prediction_res, jumpaddr, branch_flag, branch_taken,
               branch_pc, branch_target, flush, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves branches/jumps in EX, redirects fetch on mispredict, squashes the wrong path
// for FLUSH_CYCLES cycles, and emits predictor-update strobes plus performance counts.
module branch_resolve #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic              clk,
    input logic              rst,
    branch_resolve_if.slave  bus_io
);
    typedef enum logic {IDLE, SQUASH} state_e;

    localparam logic [3:0] SQUASH_INIT = 4'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        squashCnt_q, squashCnt_d;
    logic              predRes_q, predRes_d;
    logic [ADDR_W-1:0] jumpAddr_q, jumpAddr_d;
    logic              brFlag_q, brFlag_d;
    logic              brTaken_q, brTaken_d;
    logic [ADDR_W-1:0] brPc_q, brPc_d;
    logic [ADDR_W-1:0] brTarget_q, brTarget_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  brCnt_q, brCnt_d;
    logic [CNT_W-1:0]  missCnt_q, missCnt_d;

    logic              isJalr, isJal, isBr, condTaken, taken, accept, mispredict;
    logic [ADDR_W-1:0] jalrSum, target, seqPc, actualNext;

    // JALR outranks JAL, which outranks a conditional branch.
    always_comb begin
        isJalr  = bus_io.is_jalr;
        isJal   = ~bus_io.is_jalr & bus_io.is_jal;
        isBr    = ~bus_io.is_jalr & ~bus_io.is_jal & bus_io.is_br;
        condTaken = 1'b0;
        case (bus_io.funct3)
            3'b000:  condTaken = (bus_io.rs1_val == bus_io.rs2_val);
            3'b001:  condTaken = (bus_io.rs1_val != bus_io.rs2_val);
            3'b100:  condTaken = ($signed(bus_io.rs1_val) <  $signed(bus_io.rs2_val));
            3'b101:  condTaken = ($signed(bus_io.rs1_val) >= $signed(bus_io.rs2_val));
            3'b110:  condTaken = (bus_io.rs1_val <  bus_io.rs2_val);
            3'b111:  condTaken = (bus_io.rs1_val >= bus_io.rs2_val);
            default: condTaken = 1'b0;
        endcase
        taken      = isJalr | isJal | (isBr & condTaken);
        jalrSum    = bus_io.rs1_val + bus_io.imm;
        target     = isJalr ? (jalrSum & ~ADDR_W'(1)) : (bus_io.inst_pc + bus_io.imm);
        seqPc      = bus_io.inst_pc + ADDR_W'(4);
        actualNext = taken ? target : seqPc;
        mispredict = (actualNext != bus_io.pred_next_pc);
        accept     = bus_io.rdy & bus_io.ex_valid & ~bus_io.ex_stall & (state_q == IDLE) &
                     (bus_io.is_br | bus_io.is_jal | bus_io.is_jalr);
    end

    // With rdy low every register keeps its value, so a pending strobe is re-presented.
    always_comb begin
        state_d     = state_q;
        squashCnt_d = squashCnt_q;
        predRes_d   = predRes_q;
        jumpAddr_d  = jumpAddr_q;
        brFlag_d    = brFlag_q;
        brTaken_d   = brTaken_q;
        brPc_d      = brPc_q;
        brTarget_d  = brTarget_q;
        flush_d     = flush_q;
        brCnt_d     = brCnt_q;
        missCnt_d   = missCnt_q;
        if (bus_io.rdy) begin
            brFlag_d  = 1'b0;
            predRes_d = 1'b1;
            case (state_q)
                IDLE: begin
                    flush_d = 1'b0;
                    if (accept) begin
                        brCnt_d = (brCnt_q == '1) ? brCnt_q : brCnt_q + CNT_W'(1);
                        if (!isJalr) begin
                            brFlag_d   = 1'b1;
                            brTaken_d  = taken;
                            brPc_d     = bus_io.inst_pc;
                            brTarget_d = target;
                        end
                        if (mispredict) begin
                            predRes_d   = 1'b0;
                            jumpAddr_d  = actualNext;
                            flush_d     = 1'b1;
                            state_d     = SQUASH;
                            squashCnt_d = SQUASH_INIT;
                            missCnt_d   = (missCnt_q == '1) ? missCnt_q : missCnt_q + CNT_W'(1);
                        end
                    end
                end
                SQUASH: begin
                    if (squashCnt_q == 4'd0) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                    end else begin
                        squashCnt_d = squashCnt_q - 4'd1;
                        flush_d     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            squashCnt_q <= '0;
            predRes_q   <= 1'b1;
            jumpAddr_q  <= '0;
            brFlag_q    <= 1'b0;
            brTaken_q   <= 1'b0;
            brPc_q      <= '0;
            brTarget_q  <= '0;
            flush_q     <= 1'b0;
            brCnt_q     <= '0;
            missCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            squashCnt_q <= squashCnt_d;
            predRes_q   <= predRes_d;
            jumpAddr_q  <= jumpAddr_d;
            brFlag_q    <= brFlag_d;
            brTaken_q   <= brTaken_d;
            brPc_q      <= brPc_d;
            brTarget_q  <= brTarget_d;
            flush_q     <= flush_d;
            brCnt_q     <= brCnt_d;
            missCnt_q   <= missCnt_d;
        end
    end

    assign bus_io.prediction_res = predRes_q;
    assign bus_io.jumpaddr       = jumpAddr_q;
    assign bus_io.branch_flag    = brFlag_q;
    assign bus_io.branch_taken   = brTaken_q;
    assign bus_io.branch_pc      = brPc_q;
    assign bus_io.branch_target  = brTarget_q;
    assign bus_io.flush          = flush_q;
    assign bus_io.br_cnt         = brCnt_q;
    assign bus_io.miss_cnt       = missCnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed and random checks of branch_resolve against a cycle-level behavioural model.
module tb_branch_resolve;
    localparam int FLUSH = 2;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_if #(.ADDR_W(32), .CNT_W(4)) bus ();

    branch_resolve #(.ADDR_W(32), .FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    always #5 clk = ~clk;

    // Expected output state, derived from the resolution rules rather than the RTL's registers.
    bit          mPredRes, mFlag, mTaken, mFlush;
    logic [31:0] mJump, mPc, mTgt;
    int          mBr, mMiss, squashLeft;

    function automatic void resolveRef(input bit br, input bit jal, input bit jalr,
                                       input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] pc,
                                       input logic [31:0] im, output bit tk,
                                       output logic [31:0] tgt, output logic [31:0] nxt);
        tk = 1'b0;
        if (jalr) begin
            tk  = 1'b1;
            tgt = (a + im) & 32'hFFFF_FFFE;
        end else begin
            tgt = pc + im;
            if (jal) tk = 1'b1;
            else if (br) begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
            end
        end
        nxt = tk ? tgt : pc + 32'd4;
    endfunction

    task automatic modelReset();
        mPredRes = 1; mFlag = 0; mTaken = 0; mFlush = 0;
        mJump = 0; mPc = 0; mTgt = 0; mBr = 0; mMiss = 0; squashLeft = 0;
    endtask

    task automatic modelEdge();
        bit tk;
        logic [31:0] tgt, nxt;
        if (!bus.rdy) return;
        mFlag = 0;
        mPredRes = 1;
        if (squashLeft > 0) begin
            squashLeft--;
            mFlush = (squashLeft > 0);
            return;
        end
        mFlush = 0;
        if (bus.ex_valid && !bus.ex_stall && (bus.is_br || bus.is_jal || bus.is_jalr)) begin
            resolveRef(bus.is_br, bus.is_jal, bus.is_jalr, bus.funct3, bus.rs1_val,
                       bus.rs2_val, bus.inst_pc, bus.imm, tk, tgt, nxt);
            mBr = (mBr == CMAX) ? CMAX : mBr + 1;
            if (!bus.is_jalr) begin
                mFlag = 1; mTaken = tk; mPc = bus.inst_pc; mTgt = tgt;
            end
            if (nxt != bus.pred_next_pc) begin
                mPredRes = 0; mJump = nxt; mFlush = 1; squashLeft = FLUSH;
                mMiss = (mMiss == CMAX) ? CMAX : mMiss + 1;
            end
        end
    endtask

    task automatic checkOne(input string tag, input string what,
                            input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got=%0h exp=%0h", tag, what, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne(tag, "prediction_res", 32'(bus.prediction_res), 32'(mPredRes));
        checkOne(tag, "jumpaddr",       bus.jumpaddr,            mJump);
        checkOne(tag, "branch_flag",    32'(bus.branch_flag),    32'(mFlag));
        checkOne(tag, "branch_taken",   32'(bus.branch_taken),   32'(mTaken));
        checkOne(tag, "branch_pc",      bus.branch_pc,           mPc);
        checkOne(tag, "branch_target",  bus.branch_target,       mTgt);
        checkOne(tag, "flush",          32'(bus.flush),          32'(mFlush));
        checkOne(tag, "br_cnt",         32'(bus.br_cnt),         32'(mBr));
        checkOne(tag, "miss_cnt",       32'(bus.miss_cnt),       32'(mMiss));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit v, input bit st,
                                 input bit br, input bit jal, input bit jalr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc,
                                 input logic [31:0] im, input logic [31:0] pred);
        bus.rdy = r; bus.ex_valid = v; bus.ex_stall = st;
        bus.is_br = br; bus.is_jal = jal; bus.is_jalr = jalr; bus.funct3 = f3;
        bus.rs1_val = a; bus.rs2_val = b; bus.inst_pc = pc; bus.imm = im;
        bus.pred_next_pc = pred;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(tag, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'd5;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit tk;
        logic [31:0] tgt, nxt, a, b, pc, im, pred;
        bit r, v, st, br, jal, jalr;
        logic [2:0] f3;

        bus.rdy = 1; bus.ex_valid = 0; bus.ex_stall = 0;
        bus.is_br = 0; bus.is_jal = 0; bus.is_jalr = 0; bus.funct3 = 0;
        bus.rs1_val = 0; bus.rs2_val = 0; bus.inst_pc = 0; bus.imm = 0; bus.pred_next_pc = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 0;

        // Correctly predicted taken BEQ
        applyStimulus("beq", 1, 1, 0, 1, 0, 0, 3'd0, 5, 5, 32'h100, 32'h20, 32'h120);
        checkOne("beq", "target_const", bus.branch_target, 32'h120);
        checkOne("beq", "brcnt_const", 32'(bus.br_cnt), 32'd1);

        // Signed BLT mispredict, then valid BNEs arriving during the squash
        applyStimulus("blt", 1, 1, 0, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h100, 32'h40, 32'h104);
        checkOne("blt", "jump_const", bus.jumpaddr, 32'h140);
        checkOne("blt", "pres_const", 32'(bus.prediction_res), 32'd0);
        checkOne("blt", "miss_const", 32'(bus.miss_cnt), 32'd1);
        applyStimulus("sq1", 1, 1, 0, 1, 0, 0, 3'd1, 1, 2, 32'h200, 32'h8, 32'h204);
        checkOne("sq1", "flush_const", 32'(bus.flush), 32'd1);
        applyStimulus("sq2", 1, 1, 0, 1, 0, 0, 3'd1, 1, 2, 32'h200, 32'h8, 32'h204);
        checkOne("sq2", "brcnt_const", 32'(bus.br_cnt), 32'd2);
        idleStep("sqEnd");

        // Correctly predicted JALR, bit 0 of target cleared
        applyStimulus("jalr", 1, 1, 0, 0, 0, 1, 3'd0, 32'h2001, 0, 32'h50, 32'h4, 32'h2004);
        checkOne("jalr", "brcnt_const", 32'(bus.br_cnt), 32'd3);

        // Mispredicted JAL frozen by rdy=0 while the redirect is showing
        applyStimulus("jal", 1, 1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h300, 32'h10, 32'h304);
        for (int i = 0; i < 3; i++)
            applyStimulus("hold", 0, 1, 0, 1, 0, 0, 3'd0, 0, 0, 32'h400, 32'h8, 32'h0);
        checkOne("hold", "jump_const", bus.jumpaddr, 32'h310);
        idleStep("release");
        checkOne("release", "pres_const", 32'(bus.prediction_res), 32'd1);
        idleStep("release2");

        // Reset in the middle of a squash
        applyStimulus("preRst", 1, 1, 0, 1, 0, 0, 3'd0, 1, 1, 32'h500, 32'h10, 32'h504);
        #2;
        rst = 1;
        modelReset();
        #1;
        checkOutput("midRst");
        @(posedge clk);
        #1;
        rst = 0;
        idleStep("postRst1");
        idleStep("postRst2");

        // Saturation of the 4-bit miss counter
        for (int i = 0; i < 16; i++) begin
            applyStimulus("sat", 1, 1, 0, 1, 0, 0, 3'd0, 7, 7, 32'h600, 32'h20, 32'h604);
            idleStep("satSq1");
            idleStep("satSq2");
        end
        checkOne("sat", "miss_const", 32'(bus.miss_cnt), 32'hF);

        // Random traffic
        rst = 1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 9) != 0);
            v    = ($urandom_range(0, 9) < 7);
            st   = ($urandom_range(0, 4) == 0);
            br   = $urandom_range(0, 1);
            jal  = ($urandom_range(0, 3) == 0);
            jalr = ($urandom_range(0, 3) == 0);
            f3   = 3'($urandom_range(0, 7));
            a    = pickVal();
            b    = ($urandom_range(0, 3) == 0) ? a : pickVal();
            pc   = $urandom & 32'hFFFF_FFFC;
            im   = pickVal();
            resolveRef(br, jal, jalr, f3, a, b, pc, im, tk, tgt, nxt);
            case ($urandom_range(0, 2))
                0: pred = nxt;
                1: pred = pc + 32'd4;
                default: pred = $urandom;
            endcase
            applyStimulus("rand", r, v, st, br, jal, jalr, f3, a, b, pc, im, pred);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
